// File: rtl/lsu_seq.sv
// Load/store sequencer: turns one byte/half/word request into one or two aligned
// word accesses on a valid/ready memory port and returns a single response pulse.
module lsu_seq #(
   parameter int MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   localparam logic [5:0] OP_LB  = 6'd19;
   localparam logic [5:0] OP_LH  = 6'd20;
   localparam logic [5:0] OP_LW  = 6'd21;
   localparam logic [5:0] OP_LBU = 6'd22;
   localparam logic [5:0] OP_LHU = 6'd23;
   localparam logic [5:0] OP_SB  = 6'd24;
   localparam logic [5:0] OP_SH  = 6'd25;
   localparam logic [5:0] OP_SW  = 6'd26;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t              state_q, state_d;
   logic [5:0]          op_q, op_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         buf_lo_q, buf_lo_d;
   logic [23:0]         buf_hi_q, buf_hi_d;  // a split access never needs the top byte of the second word
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                err_q, err_d;
   logic                armed_q, armed_d;

   logic [2:0]          width;
   logic [3:0]          lane_mask;
   logic [7:0]          mask_sh;
   logic                is_store, is_signed, split, legal, timeout;
   logic [31:0]         wdata_rot, load_win, load_res;
   logic [WAIT_W-1:0]   wait_inc;

   // Operand decode, lane placement and load extraction for the captured request.
   always_comb begin
      width     = 3'd4;
      lane_mask = 4'b1111;
      case (op_q)
         OP_LB, OP_LBU, OP_SB: begin width = 3'd1; lane_mask = 4'b0001; end
         OP_LH, OP_LHU, OP_SH: begin width = 3'd2; lane_mask = 4'b0011; end
         default:              begin width = 3'd4; lane_mask = 4'b1111; end
      endcase
      is_store  = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
      is_signed = (op_q == OP_LB) || (op_q == OP_LH);
      split     = ({1'b0, addr_q[1:0]} + width) > 3'd4;
      mask_sh   = {4'b0000, lane_mask} << addr_q[1:0];

      case (addr_q[1:0])
         2'd0:    wdata_rot = wdata_q;
         2'd1:    wdata_rot = {wdata_q[23:0], wdata_q[31:24]};
         2'd2:    wdata_rot = {wdata_q[15:0], wdata_q[31:16]};
         default: wdata_rot = {wdata_q[7:0],  wdata_q[31:8]};
      endcase

      case (addr_q[1:0])
         2'd0:    load_win = buf_lo_q;
         2'd1:    load_win = {buf_hi_q[7:0],  buf_lo_q[31:8]};
         2'd2:    load_win = {buf_hi_q[15:0], buf_lo_q[31:16]};
         default: load_win = {buf_hi_q[23:0], buf_lo_q[31:24]};
      endcase

      case (width)
         3'd1:    load_res = {{24{is_signed & load_win[7]}},  load_win[7:0]};
         3'd2:    load_res = {{16{is_signed & load_win[15]}}, load_win[15:0]};
         default: load_res = load_win;
      endcase
   end

   assign legal    = (req_op >= OP_LB) && (req_op <= OP_SW);
   assign wait_inc = wait_q + 1'b1;
   assign timeout  = (MAX_WAIT != 0) && (wait_inc == WAIT_W'(MAX_WAIT));
   assign busy     = (state_q != IDLE);

   always_comb begin
      // NOTE: every combinationally driven signal gets a default here so no path infers a latch.
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      buf_lo_d  = buf_lo_q;
      buf_hi_d  = buf_hi_q;
      wait_d    = wait_q;
      err_d     = err_q;
      armed_d   = 1'b1;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 32'h0;
      rsp_err   = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = 32'h0;
      mem_we    = 4'b0000;
      mem_wdata = 32'h0;

      case (state_q)
         IDLE: begin
            // armed_q keeps req_ready low while reset is asserted and for the first edge after it.
            req_ready = armed_q;
            if (req_valid && armed_q) begin
               op_d     = req_op;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               buf_lo_d = 32'h0;
               buf_hi_d = 24'h0;
               wait_d   = '0;
               err_d    = !legal;
               state_d  = legal ? ACC0 : RESP;
            end
         end
         ACC0, ACC1: begin
            mem_valid = 1'b1;
            mem_addr  = {addr_q[31:2], 2'b00} + ((state_q == ACC1) ? 32'd4 : 32'd0);
            if (is_store) begin
               mem_we    = (state_q == ACC1) ? mask_sh[7:4] : mask_sh[3:0];
               mem_wdata = wdata_rot;
            end
            if (mem_ready) begin
               wait_d = '0;
               if (state_q == ACC0) begin
                  buf_lo_d = mem_rdata;
                  state_d  = split ? ACC1 : RESP;
               end else begin
                  buf_hi_d = mem_rdata[23:0];
                  state_d  = RESP;
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wait_d = wait_inc;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!err_q && !is_store) rsp_rdata = load_res;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= 6'h0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         // NOTE: the assembly buffer is reset too, so a load result never exposes pre-reset data.
         buf_lo_q <= 32'h0;
         buf_hi_q <= 24'h0;
         wait_q   <= '0;
         err_q    <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         buf_lo_q <= buf_lo_d;
         buf_hi_q <= buf_hi_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
         armed_q  <= armed_d;
      end
   end

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: each task drives one scenario against a scripted
// memory responder and compares against hand-computed expectations.
module tb_lsu_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_op = 6'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        busy;

   int tests = 0;
   int fails = 0;

   int          o_rsp_cyc, o_nacc, o_mv;
   logic [31:0] o_addr [2];
   logic [3:0]  o_we   [2];
   logic [31:0] o_wd   [2];
   logic [31:0] o_rdata;
   logic        o_err;
   logic        o_ready_after;

   lsu_seq #(.MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Issues one request, then records handshakes and the response; cycle 1 is the one after acceptance.
   task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] w0, input logic [31:0] w1, input logic rdy);
      int cyc;
      bit done;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0; mem_ready = rdy;
      o_rsp_cyc = -1; o_nacc = 0; o_mv = 0; o_rdata = 32'hx; o_err = 1'bx;
      for (int i = 0; i < 2; i++) begin o_addr[i] = 32'hx; o_we[i] = 4'hx; o_wd[i] = 32'hx; end
      done = 1'b0; cyc = 1;
      while (!done && cyc <= 40) begin
         mem_rdata = (o_nacc == 0) ? w0 : w1;
         @(negedge clk);
         if (mem_valid === 1'b1) begin
            o_mv++;
            if (mem_ready && o_nacc < 2) begin
               o_addr[o_nacc] = mem_addr; o_we[o_nacc] = mem_we; o_wd[o_nacc] = mem_wdata;
               o_nacc++;
            end
         end
         if (rsp_valid === 1'b1) begin o_rsp_cyc = cyc; o_rdata = rsp_rdata; o_err = rsp_err; done = 1'b1; end
         @(posedge clk); #1;
         cyc++;
      end
      o_ready_after = req_ready;
      mem_ready = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_lw;
      run_txn(6'd21, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0, 1'b1);
      tests++; if (o_addr[0] !== 32'h100) begin fails++; $display("FAIL lw_addr: got %h want 00000100", o_addr[0]); end
      tests++; if (o_we[0] !== 4'b0000) begin fails++; $display("FAIL lw_we: got %b want 0000", o_we[0]); end
      tests++; if (o_nacc !== 1) begin fails++; $display("FAIL lw_naccess: got %0d want 1", o_nacc); end
      tests++; if (o_rsp_cyc !== 2) begin fails++; $display("FAIL lw_latency: got %0d want 2", o_rsp_cyc); end
      tests++; if (o_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_rdata: got %h want deadbeef", o_rdata); end
      tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL lw_err: got %b want 0", o_err); end
   endtask

   task automatic test_byte_half_loads;
      run_txn(6'd19, 32'h0000_0203, 32'h0, 32'h8011_2233, 32'h0, 1'b1);
      tests++; if (o_rdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
      run_txn(6'd22, 32'h0000_0203, 32'h0, 32'h8011_2233, 32'h0, 1'b1);
      tests++; if (o_rdata !== 32'h0000_0080) begin fails++; $display("FAIL lbu_rdata: got %h want 00000080", o_rdata); end
      run_txn(6'd23, 32'h0000_0402, 32'h0, 32'h8001_7777, 32'h0, 1'b1);
      tests++; if (o_rdata !== 32'h0000_8001) begin fails++; $display("FAIL lhu_rdata: got %h want 00008001", o_rdata); end
      run_txn(6'd21, 32'h0000_0501, 32'h0, 32'h4433_2211, 32'h8877_6655, 1'b1);
      tests++; if (o_rdata !== 32'h5544_3322) begin fails++; $display("FAIL lw_split_rdata: got %h want 55443322", o_rdata); end
      tests++; if (o_rsp_cyc !== 3) begin fails++; $display("FAIL lw_split_latency: got %0d want 3", o_rsp_cyc); end
   endtask

   task automatic test_stores;
      run_txn(6'd26, 32'h0000_0106, 32'hAABB_CCDD, 32'h0, 32'h0, 1'b1);
      tests++; if (o_addr[0] !== 32'h104) begin fails++; $display("FAIL sw_addr0: got %h want 00000104", o_addr[0]); end
      tests++; if (o_we[0] !== 4'b1100) begin fails++; $display("FAIL sw_we0: got %b want 1100", o_we[0]); end
      tests++; if (o_wd[0] !== 32'hCCDD_AABB) begin fails++; $display("FAIL sw_wdata0: got %h want ccddaabb", o_wd[0]); end
      tests++; if (o_addr[1] !== 32'h108) begin fails++; $display("FAIL sw_addr1: got %h want 00000108", o_addr[1]); end
      tests++; if (o_we[1] !== 4'b0011) begin fails++; $display("FAIL sw_we1: got %b want 0011", o_we[1]); end
      tests++; if (o_wd[1] !== 32'hCCDD_AABB) begin fails++; $display("FAIL sw_wdata1: got %h want ccddaabb", o_wd[1]); end
      tests++; if (o_rsp_cyc !== 3) begin fails++; $display("FAIL sw_latency: got %0d want 3", o_rsp_cyc); end
      tests++; if (o_rdata !== 32'h0) begin fails++; $display("FAIL sw_rdata: got %h want 00000000", o_rdata); end
      run_txn(6'd25, 32'h0000_0301, 32'h0000_1234, 32'h0, 32'h0, 1'b1);
      tests++; if (o_we[0] !== 4'b0110) begin fails++; $display("FAIL sh_we: got %b want 0110", o_we[0]); end
      tests++; if (o_wd[0] !== 32'h0012_3400) begin fails++; $display("FAIL sh_wdata: got %h want 00123400", o_wd[0]); end
      tests++; if (o_rsp_cyc !== 2) begin fails++; $display("FAIL sh_latency: got %0d want 2", o_rsp_cyc); end
   endtask

   task automatic test_wrap;
      run_txn(6'd20, 32'hFFFF_FFFF, 32'h0, 32'h7F00_0000, 32'h0000_0080, 1'b1);
      tests++; if (o_addr[0] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL lh_wrap_addr0: got %h want fffffffc", o_addr[0]); end
      tests++; if (o_addr[1] !== 32'h0) begin fails++; $display("FAIL lh_wrap_addr1: got %h want 00000000", o_addr[1]); end
      tests++; if (o_rdata !== 32'hFFFF_807F) begin fails++; $display("FAIL lh_wrap_rdata: got %h want ffff807f", o_rdata); end
   endtask

   task automatic test_timeout;
      run_txn(6'd21, 32'h0000_0600, 32'h0, 32'h1234_5678, 32'h0, 1'b0);
      tests++; if (o_mv !== 4) begin fails++; $display("FAIL to_mem_valid_cycles: got %0d want 4", o_mv); end
      tests++; if (o_rsp_cyc !== 5) begin fails++; $display("FAIL to_latency: got %0d want 5", o_rsp_cyc); end
      tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b want 1", o_err); end
      tests++; if (o_rdata !== 32'h0) begin fails++; $display("FAIL to_rdata: got %h want 00000000", o_rdata); end
      tests++; if (o_ready_after !== 1'b1) begin fails++; $display("FAIL to_ready_after: got %b want 1", o_ready_after); end
   endtask

   task automatic test_illegal;
      run_txn(6'd5, 32'h0000_0700, 32'h0, 32'h0, 32'h0, 1'b1);
      tests++; if (o_mv !== 0) begin fails++; $display("FAIL ill_mem_valid_cycles: got %0d want 0", o_mv); end
      tests++; if (o_rsp_cyc !== 1) begin fails++; $display("FAIL ill_latency: got %0d want 1", o_rsp_cyc); end
      tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL ill_err: got %b want 1", o_err); end
   endtask

   task automatic test_reset_mid;
      bit saw_rsp;
      @(negedge clk);
      req_valid = 1'b1; req_op = 6'd26; req_addr = 32'h0000_0106; req_wdata = 32'hAABB_CCDD;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      tests++; if (mem_addr !== 32'h108) begin fails++; $display("FAIL mid_in_acc1: got %h want 00000108", mem_addr); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL mid_mem_valid: got %b want 0", mem_valid); end
      tests++; if (mem_we !== 4'b0) begin fails++; $display("FAIL mid_mem_we: got %b want 0000", mem_we); end
      tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL mid_mem_addr: got %h want 00000000", mem_addr); end
      tests++; if (mem_wdata !== 32'h0) begin fails++; $display("FAIL mid_mem_wdata: got %h want 00000000", mem_wdata); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", busy); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL mid_req_ready: got %b want 0", req_ready); end
      saw_rsp = 1'b0;
      repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0) saw_rsp = 1'b1; end
      rst_n = 1'b1;
      repeat (2) begin @(negedge clk); if (rsp_valid !== 1'b0) saw_rsp = 1'b1; end
      tests++; if (saw_rsp !== 1'b0) begin fails++; $display("FAIL mid_no_rsp: got %b want 0", saw_rsp); end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL mid_ready_after: got %b want 1", req_ready); end
      run_txn(6'd21, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b1);
      tests++; if (o_rdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL mid_recover_rdata: got %h want 0badf00d", o_rdata); end
      tests++; if (o_rsp_cyc !== 2) begin fails++; $display("FAIL mid_recover_latency: got %0d want 2", o_rsp_cyc); end
   endtask

   task automatic test_back_to_back;
      run_txn(6'd24, 32'h0000_0802, 32'h0000_00A5, 32'h0, 32'h0, 1'b1);
      tests++; if (o_we[0] !== 4'b0100) begin fails++; $display("FAIL b2b_sb_we: got %b want 0100", o_we[0]); end
      tests++; if (o_wd[0] !== 32'h00A5_0000) begin fails++; $display("FAIL b2b_sb_wdata: got %h want 00a50000", o_wd[0]); end
      run_txn(6'd19, 32'h0000_0801, 32'h0, 32'h0000_7F00, 32'h0, 1'b1);
      tests++; if (o_rdata !== 32'h0000_007F) begin fails++; $display("FAIL b2b_lb_rdata: got %h want 0000007f", o_rdata); end
      tests++; if (o_rsp_cyc !== 2) begin fails++; $display("FAIL b2b_lb_latency: got %0d want 2", o_rsp_cyc); end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_byte_half_loads();
      test_stores();
      test_wrap();
      test_timeout();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Multi-cycle load/store sequencer between the CPU execute stage and the word-wide data memory.
- Accepts one load or store request using the ALU op encoding 19–26 (LB, LH, LW, LBU, LHU, SB, SH, SW).
- Drives word-aligned memory accesses with a valid/ready handshake; splits misaligned halfword/word accesses into two aligned accesses.
- Returns the extended load result, or store completion, as a single response pulse.

Parameters:
- MAX_WAIT, 16: max cycles mem_valid may stay high without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer idle, request accepted this cycle if req_valid
- req_op  input  6  op code: 19 LB, 20 LH, 21 LW, 22 LBU, 23 LHU, 24 SB, 25 SH, 26 SW
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  32  load result, extended; 0 for stores and errors
- rsp_err  output  1  qualifies rsp_valid: illegal op or timeout
- mem_valid  output  1  memory access request
- mem_ready  input  1  memory accepts/completes access this cycle
- mem_addr  output  32  word-aligned address, bits [1:0]=0
- mem_we  output  4  byte-lane write enables; 0 for reads
- mem_wdata  output  32  lane-positioned store data
- mem_rdata  input  32  read data, valid when mem_valid&&mem_ready
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all outputs 0, including req_ready.
  - Captured request, assembly buffer and wait counter cleared.
  - A reset mid-operation abandons the access; no response is generated.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op, addr, wdata; compute width w (1/2/4 bytes), offset o=addr[1:0], split=(o+w>4).
  - Legal op → ACC0. Illegal op (not 19–26) → RESP with err=1 and no memory access.
- ACC0:
  - mem_valid=1; mem_addr={addr[31:2],2'b00}.
  - Stores: mem_we=(((1<<w)-1)<<o)[3:0]; mem_wdata=wdata rotated left by 8*o. Loads: mem_we=0.
  - On mem_ready: capture mem_rdata into buffer low word; go to ACC1 if split, else RESP.
- ACC1:
  - mem_addr=first word address+4, mod 2^32 (wraps 0xFFFFFFFC→0x00000000).
  - Stores: mem_we=((1<<w)-1)>>(4-o); same rotated mem_wdata.
  - On mem_ready: capture into buffer high word → RESP.
- mem_addr, mem_we and mem_wdata are held stable while mem_valid=1 and mem_ready=0. mem_valid drops in the cycle after mem_ready.
- Timeout:
  - The wait counter increments each cycle in ACC0/ACC1 with mem_ready=0 and resets on each handshake.
  - When the counter reaches MAX_WAIT (MAX_WAIT≠0): go to RESP with err=1 and deassert mem_valid.
  - An ACC1 timeout after ACC0 completed a store leaves the partial write in memory.
- RESP:
  - rsp_valid=1 for exactly one cycle; there is no response backpressure. Next state IDLE.
  - Load data: field = ({high,low} >> 8*o) low w bytes. LB/LH sign-extend; LBU/LHU zero-extend. rsp_rdata=0 when err or store.
- Latency, from the accept edge T with zero-wait memory:
  - Aligned access: mem_valid at T+1, rsp_valid at T+2.
  - Split access: rsp_valid at T+3.
  - Illegal op: rsp_valid at T+1.
  - Throughput: the next request can be accepted in the cycle after RESP.
- req_valid in non-IDLE states is ignored (req_ready=0). The request is not latched again.
- The ALU's op-code encoding is reused unchanged; the sequencer does not decode instr.

Test Plan:
- LW addr 0x100, mem_rdata 0xDEADBEEF, mem_ready tied 1:
  - mem_addr 0x100, mem_we 0.
  - rsp_valid at T+2, rsp_rdata 0xDEADBEEF, rsp_err 0.
- LB addr 0x203, word 0x80112233:
  - rsp_rdata 0xFFFFFF80.
  - Same access with LBU gives 0x00000080.
- SW addr 0x0000_0106, wdata 0xAABBCCDD:
  - First access: addr 0x104, we 4'b1100, wdata 0xCCDDAABB.
  - Second access: addr 0x108, we 4'b0011, same wdata.
  - rsp_valid at T+3.
- LH addr 0xFFFFFFFF, words 0x7F000000 then 0x00000080:
  - Second mem_addr 0x00000000 (wrap).
  - rsp_rdata 0xFFFF807F.
- MAX_WAIT=4, mem_ready held 0 on LW:
  - mem_valid high exactly 4 cycles, then rsp_valid with rsp_err=1 and rsp_rdata 0.
  - req_ready returns 1 the following cycle.
- op=5 request:
  - No mem_valid; rsp_valid at T+1 with rsp_err=1.
- Reset mid-operation: assert rst_n=0 during ACC1:
  - All outputs 0 immediately (async), no rsp_valid.
  - After release, req_ready=1 and a new request completes normally.
